// File: rtl/display_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        DigOnes,
        DigTens,
        DigHundreds,
        DigThousands
    } digit_idx_e;

    typedef struct packed {
        logic [3:0] thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       sat;
    } snapshot_t;

    // Active-low one-hot anode enable for the given digit slot.
    function automatic logic [3:0] anode_sel(digit_idx_e idx);
        logic [3:0] onehot;
        onehot = 4'b0001 << idx;
        return ~onehot;
    endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Digit/overflow inputs and multiplexed display outputs of the scan display.
// The master side supplies BCD digits; the slave side drives the display pins.
interface bcd_scan_display_if;

    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       sat;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output ones, tens, hundreds, thousands, sat,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  ones, tens, hundreds, thousands, sat,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes (10-15) render as a dash.
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 4-digit common-anode driver with per-frame snapshot,
// leading-zero blanking, one dead cycle per slot and an overflow marker.
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_scan_display_if.slave  bus
);

    localparam int unsigned    CntW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    logic [CntW-1:0] c_q, c_d;
    digit_idx_e      idx_q, idx_d;
    snapshot_t       shadow_q, shadow_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_tick_q, frame_tick_d;

    logic            wrap;
    logic            frame_load;
    logic [3:0]      digit_sel;
    logic [6:0]      seg_dec;
    logic [3:1]      lead_zero;
    logic            blank_sel;

    bcd_to_seg7 u_dec (
        .bcd_i (digit_sel),
        .seg_o (seg_dec)
    );

    // Outputs are registered from next-state values so seg/dp/an all move on
    // the same edge; the c==0 dead cycle hides the segment change.
    always_comb begin
        wrap       = (c_q == CntMax);
        c_d        = wrap ? '0 : c_q + 1'b1;
        idx_d      = wrap ? digit_idx_e'(idx_q + 2'd1) : idx_q;
        frame_load = wrap && (idx_q == DigThousands);

        shadow_d = shadow_q;
        if (frame_load) begin
            shadow_d.thousands = bus.thousands;
            shadow_d.hundreds  = bus.hundreds;
            shadow_d.tens      = bus.tens;
            shadow_d.ones      = bus.ones;
            shadow_d.sat       = bus.sat;
        end
        frame_tick_d = frame_load;

        an_d = (c_d == '0) ? AN_OFF : anode_sel(idx_d);

        digit_sel = shadow_d.ones;
        unique case (idx_d)
            DigOnes:      digit_sel = shadow_d.ones;
            DigTens:      digit_sel = shadow_d.tens;
            DigHundreds:  digit_sel = shadow_d.hundreds;
            DigThousands: digit_sel = shadow_d.thousands;
        endcase

        // Non-BCD codes are non-zero, so they stop the blanking run.
        lead_zero[3] = (shadow_d.thousands == 4'd0);
        lead_zero[2] = lead_zero[3] && (shadow_d.hundreds == 4'd0);
        lead_zero[1] = lead_zero[2] && (shadow_d.tens == 4'd0);

        blank_sel = 1'b0;
        if (BLANK_LEADING) begin
            unique case (idx_d)
                DigOnes:      blank_sel = 1'b0;
                DigTens:      blank_sel = lead_zero[1];
                DigHundreds:  blank_sel = lead_zero[2];
                DigThousands: blank_sel = lead_zero[3];
            endcase
        end

        seg_d = blank_sel ? SEG_BLANK : seg_dec;
        dp_d  = !((idx_d == DigThousands) && shadow_d.sat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q          <= '0;
            idx_q        <= DigOnes;
            shadow_q     <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            c_q          <= c_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with REFRESH_DIV=4; one instance blanks
// leading zeros and a second shows all digits, both fed the same inputs.
module tb_bcd_scan_display;

    localparam int unsigned R = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    bcd_scan_display_if bus_b ();
    bcd_scan_display_if bus_n ();

    bcd_scan_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    bcd_scan_display #(.REFRESH_DIV(R), .BLANK_LEADING(1'b0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] th, input logic [3:0] hu, input logic [3:0] te,
                          input logic [3:0] on, input logic s);
        bus_b.thousands = th; bus_b.hundreds = hu; bus_b.tens = te; bus_b.ones = on;
        bus_b.sat = s;
        bus_n.thousands = th; bus_n.hundreds = hu; bus_n.tens = te; bus_n.ones = on;
        bus_n.sat = s;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " an"}, 32'(bus_b.an), 32'hf);
        chk({tag, " seg"}, 32'(bus_b.seg), 32'(SB));
        chk({tag, " dp"}, 32'(bus_b.dp), 32'd1);
        chk({tag, " tick"}, 32'(bus_b.frame_tick), 32'd0);
        chk({tag, " an_n"}, 32'(bus_n.an), 32'hf);
        chk({tag, " seg_n"}, 32'(bus_n.seg), 32'(SB));
    endtask

    // Starts at c==0 of slot s_lo; ends at c==0 of the slot after s_hi.
    // Expected patterns are indexed by digit: [0]=ones .. [3]=thousands.
    task automatic check_slots(input int s_lo, input int s_hi, input logic [3:0][6:0] eb,
                               input logic [3:0][6:0] en, input logic dp3);
        logic [3:0] onehot;
        logic [3:0] an_exp;
        for (int s = s_lo; s <= s_hi; s++) begin
            for (int c = 0; c < int'(R); c++) begin
                onehot = 4'b0001 << s;
                an_exp = (c == 0) ? 4'hf : ~onehot;
                chk($sformatf("an s%0d c%0d", s, c), 32'(bus_b.an), 32'(an_exp));
                chk($sformatf("an_n s%0d c%0d", s, c), 32'(bus_n.an), 32'(an_exp));
                chk($sformatf("seg s%0d c%0d", s, c), 32'(bus_b.seg), 32'(eb[s]));
                chk($sformatf("seg_n s%0d c%0d", s, c), 32'(bus_n.seg), 32'(en[s]));
                chk($sformatf("dp s%0d c%0d", s, c), 32'(bus_b.dp),
                    32'((s == 3) ? dp3 : 1'b1));
                chk($sformatf("tick s%0d c%0d", s, c), 32'(bus_b.frame_tick),
                    32'((s == 0) && (c == 0)));
                step(1);
            end
        end
    endtask

    initial begin
        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step(3);
        chk_reset_vals("rst_hold");
        reset = 1'b0;
        chk_reset_vals("rst_rel");

        // Inputs present from release are only captured 16 cycles later.
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        step(15);
        chk("pre tick", 32'(bus_b.frame_tick), 32'd0);
        chk("pre an", 32'(bus_b.an), 32'h7);
        chk("pre seg", 32'(bus_b.seg), 32'(SB));
        chk("pre seg_n", 32'(bus_n.seg), 32'(S0));
        chk("pre dp", 32'(bus_b.dp), 32'd1);
        step(1);

        set_in(4'd0, 4'd0, 4'd5, 4'd0, 1'b0);
        check_slots(0, 3, {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b1);

        set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        check_slots(0, 3, {SB, SB, S5, S0}, {S0, S0, S5, S0}, 1'b1);

        set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
        check_slots(0, 3, {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0);

        check_slots(0, 3, {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b1);

        // Mid-frame input change must not leak into the current frame.
        check_slots(0, 0, {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b1);
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        check_slots(1, 3, {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b1);

        set_in(4'd0, 4'd0, 4'd0, 4'hc, 1'b0);
        check_slots(0, 3, {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b0);

        check_slots(0, 3, {SB, SB, SB, SD}, {S0, S0, S0, SD}, 1'b1);

        // Reset asserted at idx=2, c=2.
        check_slots(0, 1, {SB, SB, SB, SD}, {S0, S0, S0, SD}, 1'b1);
        chk("mid an c0", 32'(bus_b.an), 32'hf);
        step(2);
        chk("mid an c2", 32'(bus_b.an), 32'hb);
        reset = 1'b1;
        step(1);
        chk_reset_vals("rst_mid");
        chk("rst_mid dp_n", 32'(bus_n.dp), 32'd1);
        reset = 1'b0;

        // Shadow and scan restart from zero.
        step(4);
        chk("post an c0", 32'(bus_b.an), 32'hf);
        step(1);
        chk("post an c1", 32'(bus_b.an), 32'hd);
        chk("post seg", 32'(bus_b.seg), 32'(SB));
        chk("post seg_n", 32'(bus_n.seg), 32'(S0));
        chk("post tick", 32'(bus_b.frame_tick), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
